// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// State encoding is fixed so the 2-bit value can be probed directly on a debug bus.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    PllRst   = 2'd0,
    WaitLock = 2'd1,
    Stable   = 2'd2,
    Run      = 2'd3
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned PLL_RST_CYCLES_DEF = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF   = 20000;
  localparam int unsigned STABLE_CYCLES_DEF  = 1024;

  localparam int unsigned RETRY_MAX = 255;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Enough bits to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Flops reset to 0 so an unlocked PLL is assumed until proven otherwise.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL RST, waits for a stable LOCKED, then releases the system reset.
// Lock loss or lock timeout re-issues a PLL reset and bumps a saturating retry counter.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF
) (
  input  logic       clk_in1,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int unsigned MaxCycles = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CntW      = cnt_width(MaxCycles);

  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);
  localparam logic [7:0]      RetryMax    = 8'(RETRY_MAX);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      retry_q, retry_d;
  logic            lost_q, lost_d;
  logic            pll_reset_q, sys_reset_q;
  logic            retry_inc;
  logic            lost_set;
  logic            locked_s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk_in1),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_inc = 1'b0;
    lost_set  = 1'b0;

    unique case (state_q)
      PllRst: begin
        if (cnt_q == PllRstLast) begin
          state_d = WaitLock;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      WaitLock: begin
        if (locked_s) begin
          state_d = Stable;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = PllRst;
          retry_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      Stable: begin
        // A dropout here is treated as a glitch: back to waiting, no PLL reset.
        if (!locked_s) begin
          state_d = WaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = Run;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      Run: begin
        if (!locked_s) begin
          state_d   = PllRst;
          retry_inc = 1'b1;
          lost_set  = 1'b1;
        end
      end
      default: begin
        state_d = PllRst;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    retry_d = retry_q;
    if (retry_inc && (retry_q != RetryMax)) begin
      retry_d = retry_q + 8'd1;
    end

    lost_d = lost_q | lost_set;
  end

  // Outputs are decoded from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q     <= PllRst;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset_q <= (state_d == PllRst);
      sys_reset_q <= (state_d != Run);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ~sys_reset_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sits directly downstream of the PLL clock generator and runs on the free-running PLL input clock. It drives the PLL `RST` pin and consumes the PLL `LOCKED` output. It produces one `sys_reset` that is released only after lock has been stable for a programmable time. On lock loss, or if lock is never acquired, it re-issues a PLL reset automatically and counts the retries.

## Interface
- `SYNC_STAGES`, 2: flops in the `locked` synchronizer (≥2).
- `PLL_RST_CYCLES`, 16: width of each `pll_reset` pulse in cycles (≥1).
- `LOCK_TIMEOUT`, 20000: cycles to wait for lock before retrying (100 µs at 200 MHz) (≥1).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before release (≥1).
- `clk_in1  input  1`: free-running 200 MHz PLL input clock; all logic on its rising edge.
- `reset  input  1`: synchronous reset, active-high.
- `locked  input  1`: PLL LOCKED, asynchronous to this block.
- `pll_reset  output  1`: drives PLL RST; reset value 1.
- `sys_reset  output  1`: active-high reset to downstream logic; reset value 1.
- `ready  output  1`: equals `~sys_reset`; reset value 0.
- `lock_lost  output  1`: sticky; set on lock loss while in RUN; reset value 0.
- `retry_count  output  8`: saturating count of automatic PLL resets; reset value 0.

## Operation
- `locked` passes through a `SYNC_STAGES` flop chain, giving `locked_s`. Chain flops reset to 0.
- A single counter `cnt` is sized `$clog2` of the largest of the three cycle parameters. It clears on every state change.
- State machine:
  - PLL_RST (reset state):
    - `pll_reset`=1.
    - When `cnt==PLL_RST_CYCLES-1`, go to WAIT_LOCK; otherwise increment `cnt`.
    - `locked_s` is ignored.
  - WAIT_LOCK:
    - If `locked_s`=1, go to STABLE.
    - Else if `cnt==LOCK_TIMEOUT-1`, go to PLL_RST and increment `retry_count`.
    - Otherwise increment `cnt`.
  - STABLE:
    - If `locked_s`=0, go to WAIT_LOCK (glitch; no retry counted).
    - Else if `cnt==STABLE_CYCLES-1`, go to RUN.
    - Otherwise increment `cnt`.
  - RUN:
    - If `locked_s`=0, go to PLL_RST, set `lock_lost`, and increment `retry_count`.
- Output decoding:
  - `sys_reset`=1 in every state except RUN.
  - `pll_reset`=1 only in PLL_RST.
- Outputs are registered and decoded from next-state, so they change on the same edge as the state.
- `retry_count` saturates at 255 with no wrap. `lock_lost` clears only via `reset`.
- When `reset` is asserted mid-operation, the next edge forces PLL_RST with `cnt`=0 and all outputs at their reset values, regardless of current state.

## Timing
- After `reset` falls, `pll_reset` stays high for exactly `PLL_RST_CYCLES` more cycles.
- `locked` rising to `sys_reset` falling: exactly `SYNC_STAGES+1+STABLE_CYCLES` edges, provided `locked` is stable throughout.
- `locked` falling in RUN to `sys_reset` and `pll_reset` rising: exactly `SYNC_STAGES+1` edges.
- WAIT_LOCK with no lock: the timeout to PLL_RST occurs `LOCK_TIMEOUT` edges after entry.
- A `locked` glitch shorter than one cycle may be missed. The synchronizer gives no glitch guarantee.

## Structure
- Package `pll_reset_pkg`:
  - State enum with a 2-bit encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.
  - Default parameter constants.
  - `RETRY_MAX`=255.
- One sub-module, `bit_synchronizer` (parameter `STAGES`). It carries the ASYNC_REG attribute on its chain.
- Top level holds the FSM, counter and output registers only.

## Test plan
Scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, SYNC_STAGES=2.
- Reset release: hold `reset` for 3 cycles, then drop it → `pll_reset`=1 for exactly 4 cycles after release, then 0. `sys_reset`=1 and `retry_count`=0 throughout.
- Clean lock: raise `locked` 5 cycles into WAIT_LOCK and hold it → `sys_reset` falls exactly 11 edges later. `ready`=1, `lock_lost`=0.
- Lock glitch: in STABLE, drop `locked` for 3 cycles, then restore it → returns to WAIT_LOCK with no `pll_reset`. Release happens 11 edges after restore; `retry_count`=0.
- Timeout: never assert `locked` → `pll_reset` pulses 4 cycles wide every 36 cycles. `retry_count` reads 1, 2, 3, and stops at 255 after 255 pulses.
- Lock loss in RUN: drop `locked` → `sys_reset`=1 and `pll_reset`=1 after 3 edges. `lock_lost`=1 and `retry_count` increments by 1.
- Reset mid-STABLE: assert `reset` for 1 cycle → next edge shows PLL_RST state, `sys_reset`=1, `lock_lost`=0, `retry_count`=0.
